// File: rtl/sync_fifo_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mp_pkg
// Purpose  : Shared constants and width helpers for the multi-port FIFO.
//            ptr_width() gives the (log2(DEPTH)+1)-bit pointer/count width,
//            num_width() gives the width of a per-cycle push/pop count.
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_mp_pkg;

    // Memory initialisation applied while reset is asserted
    localparam int C_RESET_MODE_NONE = 0;  // contents left undefined
    localparam int C_RESET_MODE_ZERO = 1;  // all entries cleared
    localparam int C_RESET_MODE_FRL  = 3;  // mem[i] = i, FIFO starts full

    // One extra pointer bit distinguishes full from empty
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Enough bits to encode 0..nports
    function automatic int num_width(input int nports);
        return $clog2(nports + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mp_ptr.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mp_ptr
// Purpose  : One FIFO pointer: reset value, override load, optional
//            checkpoint save/restore and advance by a variable amount.
//            Priority: reset > override > restore > advance.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            adv_en_i/adv_num_i  - advance pointer by adv_num_i
//            chg_en_i/chg_val_i  - load chg_val_i
//            ckpt_save_i         - capture the post-update pointer value
//            ckpt_restore_i      - reload pointer from the checkpoint
//            ptr_o               - current pointer
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mp_ptr #(
    parameter int              PW      = 6,
    parameter logic [PW-1:0]   RST_VAL = '0,
    parameter bit              CKPT_EN = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv_en_i,
    input  logic [PW-1:0] adv_num_i,
    input  logic          chg_en_i,
    input  logic [PW-1:0] chg_val_i,
    input  logic          ckpt_save_i,
    input  logic          ckpt_restore_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] ckpt_val;
    logic          restore_act;

    always_comb begin
        ptr_d = ptr_q;
        if (chg_en_i) begin
            ptr_d = chg_val_i;
        end else if (restore_act) begin
            ptr_d = ckpt_val;
        end else if (adv_en_i) begin
            ptr_d = ptr_q + adv_num_i;   // wraps mod 2^PW
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= RST_VAL;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    generate
        if (CKPT_EN) begin : g_ckpt
            logic [PW-1:0] ckpt_q;
            // Save captures the value the pointer takes at this edge; a
            // simultaneous restore wins and leaves the checkpoint untouched.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ckpt_q <= RST_VAL;
                end else if (ckpt_save_i && !ckpt_restore_i) begin
                    ckpt_q <= ptr_d;
                end
            end
            assign ckpt_val    = ckpt_q;
            assign restore_act = ckpt_restore_i;
        end else begin : g_no_ckpt
            logic unused_ckpt;
            assign unused_ckpt = ckpt_save_i | ckpt_restore_i;
            assign ckpt_val    = '0;
            assign restore_act = 1'b0;
        end
    endgenerate

    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_mp.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mp
// Purpose  : Synchronous FIFO accepting up to N_WR pushes and N_RD pops per
//            cycle (all-or-nothing per side), combinational read of the first
//            N_RD entries, pointer override for flush/recovery.
//            Optional write-pointer checkpoint enabled by the macro
//            SYNC_FIFO_MP_CHECKPOINT_EN (ckpt_* inputs ignored without it).
// Ports    : clk, reset            - clock, synchronous active-high reset
//            w_num, din            - push count and data (slot 0 = low bits)
//            w_ptr, w_fail         - write pointer, push rejected
//            r_num                 - pop count
//            dout, dout_valid      - head entries and their validity
//            r_ptr, r_fail         - read pointer, pop rejected
//            count, full, empty    - occupancy and flags
//            change_{r,w}_ptr_*    - pointer override enable/value
//            ckpt_save/ckpt_restore- write-pointer checkpoint controls
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mp
    import sync_fifo_mp_pkg::*;
#(
    parameter  int DEPTH      = 32,
    parameter  int WIDTH      = 32,
    parameter  int N_WR       = 2,
    parameter  int N_RD       = 2,
    parameter  int RESET_MODE = C_RESET_MODE_NONE,
    localparam int PW         = ptr_width(DEPTH),
    localparam int WN         = num_width(N_WR),
    localparam int RN         = num_width(N_RD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WN-1:0]         w_num,
    input  logic [N_WR*WIDTH-1:0] din,
    output logic [PW-1:0]         w_ptr,
    output logic                  w_fail,
    input  logic [RN-1:0]         r_num,
    output logic [N_RD*WIDTH-1:0] dout,
    output logic [N_RD-1:0]       dout_valid,
    output logic [PW-1:0]         r_ptr,
    output logic                  r_fail,
    output logic [PW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    input  logic                  change_r_ptr_en,
    input  logic                  change_w_ptr_en,
    input  logic [PW-1:0]         change_r_ptr_value,
    input  logic [PW-1:0]         change_w_ptr_value,
    input  logic                  ckpt_save,
    input  logic                  ckpt_restore
);

    localparam int            AW       = PW - 1;
    localparam logic [PW-1:0] C_DEPTH  = PW'(DEPTH);
    localparam logic [PW-1:0] C_W_RST  = (RESET_MODE == C_RESET_MODE_FRL) ? PW'(DEPTH) : {PW{1'b0}};

`ifdef SYNC_FIFO_MP_CHECKPOINT_EN
    localparam bit CKPT_EN = 1'b1;
    logic ckpt_restore_act;
    assign ckpt_restore_act = ckpt_restore;
`else
    localparam bit CKPT_EN = 1'b0;
    logic ckpt_restore_act;
    assign ckpt_restore_act = 1'b0;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    free;
    logic [PW-1:0]    w_num_ext;
    logic [PW-1:0]    r_num_ext;
    logic             push_ok;
    logic             pop_ok;
    logic [AW-1:0]    wr_idx [N_WR];
    logic [AW-1:0]    rd_idx [N_RD];

    assign w_num_ext = PW'(w_num);
    assign r_num_ext = PW'(r_num);

    // Occupancy from registered pointers only: same-cycle pops never make
    // room for same-cycle pushes and vice versa.
    assign count = w_ptr - r_ptr;
    assign free  = C_DEPTH - count;
    assign full  = (count == C_DEPTH);
    assign empty = (count == '0);

    assign push_ok = !change_w_ptr_en && !ckpt_restore_act
                     && (w_num_ext <= PW'(N_WR)) && (w_num_ext <= free);
    assign pop_ok  = !change_r_ptr_en
                     && (r_num_ext <= PW'(N_RD)) && (r_num_ext <= count);

    assign w_fail = (w_num != '0) && !push_ok;
    assign r_fail = (r_num != '0) && !pop_ok;

    // Memory index is the low AW bits, so slot offsets wrap DEPTH-1 -> 0.
    generate
        for (genvar k = 0; k < N_WR; k++) begin : g_wr_idx
            assign wr_idx[k] = w_ptr[AW-1:0] + AW'(k);
        end
        for (genvar k = 0; k < N_RD; k++) begin : g_rd
            assign rd_idx[k]                 = r_ptr[AW-1:0] + AW'(k);
            assign dout[k*WIDTH +: WIDTH]    = mem_q[rd_idx[k]];
            assign dout_valid[k]             = (PW'(k) < count);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_MODE == C_RESET_MODE_ZERO) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (RESET_MODE == C_RESET_MODE_FRL) begin
                // Free-register-list preload: entry i holds register tag i
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= WIDTH'(i);
                end
            end
        end else if (push_ok) begin
            for (int k = 0; k < N_WR; k++) begin
                if (PW'(k) < w_num_ext) begin
                    mem_q[wr_idx[k]] <= din[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    sync_fifo_mp_ptr #(
        .PW      (PW),
        .RST_VAL (C_W_RST),
        .CKPT_EN (CKPT_EN)
    ) u_w_ptr (
        .clk            (clk),
        .reset          (reset),
        .adv_en_i       (push_ok),
        .adv_num_i      (w_num_ext),
        .chg_en_i       (change_w_ptr_en),
        .chg_val_i      (change_w_ptr_value),
        .ckpt_save_i    (ckpt_save),
        .ckpt_restore_i (ckpt_restore),
        .ptr_o          (w_ptr)
    );

    sync_fifo_mp_ptr #(
        .PW      (PW),
        .RST_VAL ({PW{1'b0}}),
        .CKPT_EN (1'b0)
    ) u_r_ptr (
        .clk            (clk),
        .reset          (reset),
        .adv_en_i       (pop_ok),
        .adv_num_i      (r_num_ext),
        .chg_en_i       (change_r_ptr_en),
        .chg_val_i      (change_r_ptr_value),
        .ckpt_save_i    (1'b0),
        .ckpt_restore_i (1'b0),
        .ptr_o          (r_ptr)
    );

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_mp
// Purpose  : Self-checking bench for sync_fifo_mp. A DEPTH=8 instance is
//            exercised with a directed vector table, hand-written wrap and
//            override sequences and a randomized run against a reference
//            model; a DEPTH=128 free-register-list instance checks the
//            preloaded reset state and the checkpoint behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_mp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT: DEPTH 8, WIDTH 8, 2x2 ports ----------------
    logic [1:0]  w_num, r_num;
    logic [15:0] din, dout;
    logic [3:0]  w_ptr, r_ptr, count;
    logic [1:0]  dout_valid;
    logic        w_fail, r_fail, full, empty;
    logic        change_r_ptr_en, change_w_ptr_en;
    logic [3:0]  change_r_ptr_value, change_w_ptr_value;

    sync_fifo_mp #(.DEPTH(8), .WIDTH(8), .N_WR(2), .N_RD(2), .RESET_MODE(0)) u_dut (
        .clk(clk), .reset(reset), .w_num(w_num), .din(din), .w_ptr(w_ptr),
        .w_fail(w_fail), .r_num(r_num), .dout(dout), .dout_valid(dout_valid),
        .r_ptr(r_ptr), .r_fail(r_fail), .count(count), .full(full), .empty(empty),
        .change_r_ptr_en(change_r_ptr_en), .change_w_ptr_en(change_w_ptr_en),
        .change_r_ptr_value(change_r_ptr_value), .change_w_ptr_value(change_w_ptr_value),
        .ckpt_save(1'b0), .ckpt_restore(1'b0)
    );

    // ---------------- FRL DUT: DEPTH 128, RESET_MODE 3 ----------------
    logic [1:0]  f_w_num, f_r_num;
    logic [15:0] f_din, f_dout;
    logic [7:0]  f_w_ptr, f_r_ptr, f_count;
    logic [1:0]  f_dout_valid;
    logic        f_w_fail, f_r_fail, f_full, f_empty;
    logic        f_ckpt_save, f_ckpt_restore;

    sync_fifo_mp #(.DEPTH(128), .WIDTH(8), .N_WR(2), .N_RD(2), .RESET_MODE(3)) u_frl (
        .clk(clk), .reset(reset), .w_num(f_w_num), .din(f_din), .w_ptr(f_w_ptr),
        .w_fail(f_w_fail), .r_num(f_r_num), .dout(f_dout), .dout_valid(f_dout_valid),
        .r_ptr(f_r_ptr), .r_fail(f_r_fail), .count(f_count), .full(f_full), .empty(f_empty),
        .change_r_ptr_en(1'b0), .change_w_ptr_en(1'b0),
        .change_r_ptr_value(8'd0), .change_w_ptr_value(8'd0),
        .ckpt_save(f_ckpt_save), .ckpt_restore(f_ckpt_restore)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (DEPTH 8) ----------------
    int         m_wp, m_rp, n_wp, n_rp;   // pointers mod 16
    logic [7:0] m_mem [8];

    // Apply inputs, check combinational outputs against the model, and
    // compute the model's next state.
    task automatic drive(input logic [1:0] wn, input logic [15:0] d, input logic [1:0] rn,
                         input logic cwe, input logic [3:0] cwv,
                         input logic cre, input logic [3:0] crv);
        int          cnt;
        bit          p_ok, q_ok;
        logic [15:0] e_d, mask;
        logic [1:0]  e_v;
        w_num = wn; din = d; r_num = rn;
        change_w_ptr_en = cwe; change_w_ptr_value = cwv;
        change_r_ptr_en = cre; change_r_ptr_value = crv;
        #1;
        cnt  = (m_wp - m_rp) & 15;
        p_ok = !cwe && (int'(wn) <= 2) && (int'(wn) <= 8 - cnt);
        q_ok = !cre && (int'(rn) <= 2) && (int'(rn) <= cnt);
        for (int k = 0; k < 2; k++) begin
            e_v[k]         = (k < cnt);
            e_d[k*8 +: 8]  = m_mem[(m_rp + k) % 8];
            mask[k*8 +: 8] = e_v[k] ? 8'hFF : 8'h00;
        end
        chk("m_w_fail", w_fail, (wn != 0) && !p_ok);
        chk("m_r_fail", r_fail, (rn != 0) && !q_ok);
        chk("m_count", count, cnt);
        chk("m_full", full, cnt == 8);
        chk("m_empty", empty, cnt == 0);
        chk("m_w_ptr", w_ptr, m_wp);
        chk("m_r_ptr", r_ptr, m_rp);
        chk("m_valid", dout_valid, e_v);
        chk("m_dout", dout & mask, e_d & mask);
        n_wp = m_wp; n_rp = m_rp;
        if (cwe) n_wp = cwv;
        else if (p_ok) begin
            for (int k = 0; k < int'(wn); k++) m_mem[(m_wp + k) % 8] = d[k*8 +: 8];
            n_wp = (m_wp + wn) & 15;
        end
        if (cre) n_rp = crv;
        else if (q_ok) n_rp = (m_rp + rn) & 15;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_wp = n_wp;
        m_rp = n_rp;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  wn;
        logic [15:0] d;
        logic [1:0]  rn;
        logic        ewf, erf;
        logic [1:0]  ev;
        logic [15:0] ed;      // compared only in slots flagged by ev
        logic [3:0]  ewp, erp, ecnt;   // after the edge
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [15:0] msk;

        tbl[0]  = '{2'd2, 16'hB1A1, 2'd0, 1'b0, 1'b0, 2'b00, 16'h0000, 4'd2,  4'd0,  4'd2};
        tbl[1]  = '{2'd2, 16'hB2A2, 2'd0, 1'b0, 1'b0, 2'b11, 16'hB1A1, 4'd4,  4'd0,  4'd4};
        tbl[2]  = '{2'd2, 16'hB3A3, 2'd0, 1'b0, 1'b0, 2'b11, 16'hB1A1, 4'd6,  4'd0,  4'd6};
        tbl[3]  = '{2'd2, 16'hB4A4, 2'd0, 1'b0, 1'b0, 2'b11, 16'hB1A1, 4'd8,  4'd0,  4'd8};
        tbl[4]  = '{2'd1, 16'h00C5, 2'd0, 1'b1, 1'b0, 2'b11, 16'hB1A1, 4'd8,  4'd0,  4'd8};
        tbl[5]  = '{2'd2, 16'hEEEE, 2'd2, 1'b1, 1'b0, 2'b11, 16'hB1A1, 4'd8,  4'd2,  4'd6};
        tbl[6]  = '{2'd0, 16'h0000, 2'd3, 1'b0, 1'b1, 2'b11, 16'hB2A2, 4'd8,  4'd2,  4'd6};
        tbl[7]  = '{2'd3, 16'hFFFF, 2'd0, 1'b1, 1'b0, 2'b11, 16'hB2A2, 4'd8,  4'd2,  4'd6};
        tbl[8]  = '{2'd2, 16'hD8C8, 2'd2, 1'b0, 1'b0, 2'b11, 16'hB2A2, 4'd10, 4'd4,  4'd6};
        tbl[9]  = '{2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 2'b11, 16'hB3A3, 4'd10, 4'd6,  4'd4};
        tbl[10] = '{2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 2'b11, 16'hB4A4, 4'd10, 4'd8,  4'd2};
        tbl[11] = '{2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 2'b11, 16'hD8C8, 4'd10, 4'd10, 4'd0};
        tbl[12] = '{2'd1, 16'h00E9, 2'd1, 1'b0, 1'b1, 2'b00, 16'h0000, 4'd11, 4'd10, 4'd1};
        tbl[13] = '{2'd1, 16'h00EA, 2'd2, 1'b0, 1'b1, 2'b01, 16'h00E9, 4'd12, 4'd10, 4'd2};

        reset = 1'b1;
        w_num = '0; r_num = '0; din = '0;
        change_r_ptr_en = 1'b0; change_w_ptr_en = 1'b0;
        change_r_ptr_value = '0; change_w_ptr_value = '0;
        f_w_num = '0; f_r_num = '0; f_din = '0;
        f_ckpt_save = 1'b0; f_ckpt_restore = 1'b0;
        m_wp = 0; m_rp = 0; n_wp = 0; n_rp = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_w_ptr", w_ptr, 0);
        chk("rst_r_ptr", r_ptr, 0);
        chk("rst_valid", dout_valid, 2'b00);
        chk("rst_w_fail", w_fail, 0);
        chk("rst_r_fail", r_fail, 0);
        chk("frl_rst_full", f_full, 1);
        chk("frl_rst_count", f_count, 128);
        chk("frl_rst_w_ptr", f_w_ptr, 128);
        chk("frl_rst_r_ptr", f_r_ptr, 0);

        // directed table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].wn, tbl[i].d, tbl[i].rn, 1'b0, 4'd0, 1'b0, 4'd0);
            msk = {{8{tbl[i].ev[1]}}, {8{tbl[i].ev[0]}}};
            chk("tbl_w_fail", w_fail, tbl[i].ewf);
            chk("tbl_r_fail", r_fail, tbl[i].erf);
            chk("tbl_valid", dout_valid, tbl[i].ev);
            chk("tbl_dout", dout & msk, tbl[i].ed & msk);
            tick();
            chk("tbl_w_ptr", w_ptr, tbl[i].ewp);
            chk("tbl_r_ptr", r_ptr, tbl[i].erp);
            chk("tbl_count", count, tbl[i].ecnt);
        end

        // wrap: both pointers to 7, then a two-slot push straddling 7 -> 0
        drive(2'd2, 16'h2211, 2'd0, 1'b1, 4'd7, 1'b1, 4'd7);
        chk("ovr_w_fail", w_fail, 1);
        tick();
        chk("ovr_w_ptr7", w_ptr, 7);
        chk("ovr_r_ptr7", r_ptr, 7);
        drive(2'd2, 16'hDDCC, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("wrap_w_fail", w_fail, 0);
        tick();
        chk("wrap_w_ptr", w_ptr, 9);
        drive(2'd0, 16'h0000, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("wrap_dout", dout, 16'hDDCC);
        chk("wrap_valid", dout_valid, 2'b11);
        tick();

        // override blocks the push and the memory keeps its old contents
        drive(2'd2, 16'hFFEE, 2'd0, 1'b1, 4'd3, 1'b1, 4'd1);
        chk("chg_w_fail", w_fail, 1);
        tick();
        chk("chg_w_ptr", w_ptr, 3);
        chk("chg_r_ptr", r_ptr, 1);
        drive(2'd0, 16'h0000, 2'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("chg_dout", dout, 16'hE9D8);
        tick();

        // randomized run against the model; occupancy kept within 0..8
        for (int i = 0; i < 400; i++) begin
            logic [1:0] wn, rn;
            logic       cwe, cre;
            logic [3:0] cwv, crv;
            int         sel;
            wn  = 2'($urandom_range(0, 3));
            rn  = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 19));
            cwe = 1'b0; cre = 1'b0; cwv = '0; crv = '0;
            if (sel == 0) begin
                cwe = 1'b1; rn = 2'd0;
                cwv = 4'((m_rp + int'($urandom_range(0, 8))) & 15);
            end else if (sel == 1) begin
                cre = 1'b1; wn = 2'd0;
                crv = 4'((m_wp - int'($urandom_range(0, 8))) & 15);
            end
            drive(wn, 16'($urandom), rn, cwe, cwv, cre, crv);
            tick();
        end

        // free-register-list instance: preloaded tags popped in order
        f_r_num = 2'd2;
        #1;
        chk("frl_dout0", f_dout, 16'h0100);
        chk("frl_valid", f_dout_valid, 2'b11);
        chk("frl_r_fail", f_r_fail, 0);
        @(posedge clk); #1;
        f_r_num = 2'd0;
        chk("frl_r_ptr", f_r_ptr, 2);
        chk("frl_dout1", f_dout, 16'h0302);
        chk("frl_count", f_count, 126);
`ifdef SYNC_FIFO_MP_CHECKPOINT_EN
        f_w_num = 2'd2; f_din = 16'hBBAA; f_ckpt_save = 1'b1;
        @(posedge clk); #1;
        f_w_num = 2'd0; f_ckpt_save = 1'b0;
        chk("ckpt_w_ptr_save", f_w_ptr, 130);
        f_r_num = 2'd2;
        @(posedge clk); #1;
        f_r_num = 2'd0; f_w_num = 2'd2;
        @(posedge clk); #1;
        f_w_num = 2'd0;
        chk("ckpt_w_ptr_adv", f_w_ptr, 132);
        f_ckpt_restore = 1'b1; f_w_num = 2'd1;
        #1;
        chk("ckpt_w_fail", f_w_fail, 1);
        @(posedge clk); #1;
        f_ckpt_restore = 1'b0; f_w_num = 2'd0;
        chk("ckpt_w_ptr_rest", f_w_ptr, 130);
`else
        f_ckpt_save = 1'b1; f_ckpt_restore = 1'b1; f_w_num = 2'd1; f_din = 16'h0077;
        #1;
        chk("nockpt_w_fail", f_w_fail, 0);
        @(posedge clk); #1;
        f_ckpt_save = 1'b0; f_ckpt_restore = 1'b0; f_w_num = 2'd0;
        chk("nockpt_w_ptr", f_w_ptr, 129);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
